mux21_rr_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the 2-bit 2:1 registered mux datapath.
//  Two requesters present data with valid/ready handshakes. The block grants one requester at a time.
//  It drives the mux selector and registers the winning beat into a single output stage with downstream backpressure.
//  A burst limit forces handover so that neither requester can starve the other.

---
 rtl/mux21_rr_arbiter_pkg.sv | 9 +
 rtl/mux21_rr_arbiter_fsm.sv | 61 ++++++
 rtl/mux21_rr_arbiter.sv | 47 ++++
 tb/tb_mux21_rr_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mux21_rr_arbiter_pkg.sv
// mux21_rr_arbiter_pkg: shared state encoding, defaults and grant helper for the round-robin arbiter
package mux21_rr_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SERVE0 = 2'd1, SERVE1 = 2'd2} state_t;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_MAX_BURST = 4;
  function automatic state_t serve(input logic x);
    return x ? SERVE1 : SERVE0;
  endfunction
endpackage

// File: rtl/mux21_rr_arbiter_fsm.sv
// rr_burst_fsm: round-robin ownership, burst counting and registered mux selector
module rr_burst_fsm
  import mux21_rr_arbiter_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       beat0,
  input  logic       beat1,
  output logic [1:0] state,
  output logic       selector
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t st, st_n;
  logic last, last_n, own, vx, vo, bx, sel_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  assign state = st;
  always_comb begin
    own = (st == SERVE1);
    vx = own ? valid1 : valid0;
    vo = own ? valid0 : valid1;
    bx = own ? beat1 : beat0;
    cnt_inc = cnt + 1'b1;
    st_n = st;
    last_n = last;
    cnt_n = cnt;
    if (st == IDLE) begin
      if (valid0 | valid1) st_n = (valid0 & valid1) ? serve(!last) : serve(valid1);
    end else if (!vx) begin
      st_n = vo ? serve(!own) : IDLE;
      last_n = own;
      cnt_n = '0;
    end else if (bx) begin
      if (cnt_inc == CW'(MAX_BURST)) begin
        cnt_n = '0;
        if (vo) begin
          st_n = serve(!own);
          last_n = own;
        end
      end else cnt_n = cnt_inc;
    end
    // selector follows the owner and keeps the last owner while idle
    sel_n = (st_n == SERVE1) | ((st_n == IDLE) & selector);
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      st <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      selector <= 1'b0;
    end else begin
      st <= st_n;
      last <= last_n;
      cnt <= cnt_n;
      selector <= sel_n;
    end
  end
endmodule

// File: rtl/mux21_rr_arbiter.sv
// mux21_rr_arbiter: two-requester round-robin arbiter driving a registered 2:1 mux output stage
module mux21_rr_arbiter
  import mux21_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             valid_in0,
  input  logic [WIDTH-1:0] data_in0,
  output logic             ready_out0,
  input  logic             valid_in1,
  input  logic [WIDTH-1:0] data_in1,
  output logic             ready_out1,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             selector
);
  logic [1:0] state;
  logic out_free, beat0, beat1;
  assign out_free = !valid_out | ready_in;
  assign ready_out0 = (state == SERVE0) & out_free;
  assign ready_out1 = (state == SERVE1) & out_free;
  assign beat0 = valid_in0 & ready_out0;
  assign beat1 = valid_in1 & ready_out1;
  rr_burst_fsm #(.MAX_BURST(MAX_BURST)) u_fsm (
    .clk(clk),
    .reset_L(reset_L),
    .valid0(valid_in0),
    .valid1(valid_in1),
    .beat0(beat0),
    .beat1(beat1),
    .state(state),
    .selector(selector)
  );
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out <= '0;
      valid_out <= 1'b0;
    end else if (beat0 | beat1) begin
      data_out <= selector ? data_in1 : data_in0;
      valid_out <= 1'b1;
    end else if (ready_in) valid_out <= 1'b0;
  end
endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// tb_mux21_rr_arbiter: directed checks of reset, streaming, contention, backpressure and early release
module tb_mux21_rr_arbiter;
  logic clk = 1'b0, reset_L = 1'b0;
  logic valid_in0 = 1'b0, valid_in1 = 1'b0, ready_in = 1'b0;
  logic [1:0] data_in0 = '0, data_in1 = '0;
  logic ready_out0, ready_out1, valid_out, selector;
  logic [1:0] data_out;
  int total = 0, bad = 0;
  logic [1:0] seq [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

  mux21_rr_arbiter dut (
    .clk(clk), .reset_L(reset_L),
    .valid_in0(valid_in0), .data_in0(data_in0), .ready_out0(ready_out0),
    .valid_in1(valid_in1), .data_in1(data_in1), .ready_out1(ready_out1),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .selector(selector)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) begin
      @(negedge clk);
      {valid_in0, valid_in1, ready_in} = 3'($urandom);
      data_in0 = 2'($urandom);
      data_in1 = 2'($urandom);
      #1;
      chk("rst_valid", valid_out, 0);
      chk("rst_data", data_out, 0);
      chk("rst_sel", selector, 0);
      chk("rst_ready0", ready_out0, 0);
      chk("rst_ready1", ready_out1, 0);
    end
    @(negedge clk);
    reset_L = 1; valid_in0 = 1; valid_in1 = 0; ready_in = 1; data_in0 = seq[0];
    #1 chk("idle_ready0", ready_out0, 0);
    @(negedge clk);
    chk("arb_ready0", ready_out0, 1);
    chk("arb_valid", valid_out, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("single_data", data_out, seq[i]);
      chk("single_valid", valid_out, 1);
      chk("single_sel", selector, 0);
      if (i < 5) data_in0 = seq[i+1];
    end
    valid_in0 = 0;
    @(negedge clk);
    chk("drain_valid", valid_out, 0);
    chk("drain_hold", data_out, 2);

    reset_L = 0;
    @(negedge clk);
    reset_L = 1; valid_in0 = 1; valid_in1 = 1; data_in0 = 2'b01; data_in1 = 2'b10; ready_in = 1;
    @(negedge clk);
    for (int e = 2; e <= 13; e++) begin
      @(negedge clk);
      chk("cont_data", data_out, (e < 6 || e > 9) ? 2'b01 : 2'b10);
      chk("cont_sel", selector, ((e >= 5 && e <= 8) || e >= 13) ? 1 : 0);
    end

    data_in1 = 3;
    @(negedge clk);
    chk("bp_pre1", data_out, 3);
    @(negedge clk);
    chk("bp_pre2", data_out, 3);
    ready_in = 0; data_in1 = 0;
    #1 chk("bp_ready1", ready_out1, 0);
    chk("bp_ready0", ready_out0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", data_out, 3);
      chk("bp_valid", valid_out, 1);
      chk("bp_rdy", ready_out1, 0);
    end
    ready_in = 1; data_in1 = 1; data_in0 = 0;
    @(negedge clk);
    chk("resume_data", data_out, 1);
    chk("resume_sel", selector, 1);
    @(negedge clk);
    chk("last_beat_data", data_out, 1);
    chk("handover_sel", selector, 0);
    @(negedge clk);
    chk("new_owner_data", data_out, 0);
    chk("new_owner_sel", selector, 0);

    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("er_pre_data", data_out, 0);
    chk("er_pre_sel", selector, 1);
    data_in1 = 2;
    @(negedge clk);
    chk("er_b1", data_out, 2);
    @(negedge clk);
    chk("er_b2", data_out, 2);
    valid_in1 = 0;
    @(negedge clk);
    chk("er_sel", selector, 0);
    chk("er_valid", valid_out, 0);
    data_in0 = 3;
    #1 chk("er_ready0", ready_out0, 1);
    @(negedge clk);
    chk("er_beat0", data_out, 3);
    chk("er_valid0", valid_out, 1);
    valid_in0 = 0;
    @(negedge clk);
    chk("idle_valid", valid_out, 0);
    chk("idle_sel", selector, 0);
    valid_in0 = 1; valid_in1 = 1;
    @(negedge clk);
    chk("tie_sel", selector, 1);
    chk("tie_ready1", ready_out1, 1);
    chk("tie_ready0", ready_out0, 0);
    @(negedge clk);
    chk("tie_data", data_out, 2);
    chk("tie_valid", valid_out, 1);

    #2 reset_L = 0;
    #1 chk("async_valid", valid_out, 0);
    chk("async_data", data_out, 0);
    chk("async_sel", selector, 0);
    @(negedge clk);
    reset_L = 1; data_in0 = 1; data_in1 = 2;
    @(negedge clk);
    chk("restart_sel", selector, 0);
    chk("restart_ready0", ready_out0, 1);
    @(negedge clk);
    chk("restart_data", data_out, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
